// File: rtl/conv_loop_engine.sv
// rtl/conv_loop_engine.sv - sequential direct-convolution engine, one signed MAC per clock, streamed pixel results
// Optional feature macro: CONV_RELU_EN clamps negative pixel sums to zero on output.
module conv_loop_engine #(
   parameter int DW     = 8,
   parameter int IN_CH  = 3,
   parameter int IN_DIM = 12,
   parameter int K      = 3,
   parameter int OUT_CH = 7,
   parameter int STRIDE = 1,
   parameter int ACCW   = 24
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start,
   input  logic [IN_CH*IN_DIM*IN_DIM*DW-1:0]        input_fm,
   input  logic [OUT_CH*IN_CH*K*K*DW-1:0]           weights,
   output logic                                     busy,
   output logic                                     out_valid,
   output logic [ACCW-1:0]                          out_data,
   output logic [(OUT_CH > 1 ? $clog2(OUT_CH) : 1)-1:0] out_ch,
   output logic [((((IN_DIM-K)/STRIDE+1) > 1) ? $clog2((IN_DIM-K)/STRIDE+1) : 1)-1:0] out_row,
   output logic [((((IN_DIM-K)/STRIDE+1) > 1) ? $clog2((IN_DIM-K)/STRIDE+1) : 1)-1:0] out_col,
   output logic                                     done
);

   localparam int OUT_DIM = (IN_DIM - K) / STRIDE + 1;
   localparam int OCW     = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
   localparam int ODW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam int ICW     = (IN_CH > 1) ? $clog2(IN_CH) : 1;
   localparam int KW      = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;
   state_t state, state_nx;

   logic [IN_CH*IN_DIM*IN_DIM*DW-1:0] fm_q;
   logic [OUT_CH*IN_CH*K*K*DW-1:0]    w_q;

   logic [OCW-1:0] o_cnt;
   logic [ODW-1:0] row_cnt, col_cnt;
   logic [ICW-1:0] c_cnt;
   logic [KW-1:0]  i_cnt, j_cnt;
   logic signed [ACCW-1:0] acc;

   logic do_load, do_mac, do_emit, do_fin;
   logic last_prod, last_pix;

   int fm_idx, w_idx;
   logic signed [DW-1:0]     act, wt;
   logic signed [2*DW-1:0]   prod;
   logic signed [ACCW-1:0]   prod_ext;
   logic signed [ACCW-1:0]   emit_val;

   assign last_prod = (c_cnt == ICW'(IN_CH-1)) && (i_cnt == KW'(K-1)) && (j_cnt == KW'(K-1));
   assign last_pix  = (o_cnt == OCW'(OUT_CH-1)) && (row_cnt == ODW'(OUT_DIM-1)) &&
                      (col_cnt == ODW'(OUT_DIM-1));

   always_comb begin
      fm_idx = ((int'(c_cnt) * IN_DIM + int'(row_cnt) * STRIDE + int'(i_cnt)) * IN_DIM +
                int'(col_cnt) * STRIDE + int'(j_cnt)) * DW;
      w_idx  = (((int'(o_cnt) * IN_CH + int'(c_cnt)) * K + int'(i_cnt)) * K + int'(j_cnt)) * DW;
   end

   assign act      = fm_q[fm_idx +: DW];
   assign wt       = w_q[w_idx +: DW];
   assign prod     = act * wt;
   assign prod_ext = ACCW'(prod);

`ifdef CONV_RELU_EN
   assign emit_val = acc[ACCW-1] ? '0 : acc;
`else
   assign emit_val = acc;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // done is still high in the first IDLE cycle; a start seen then is dropped
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (start && !done) state_nx = S_MAC;
         S_MAC:  if (last_prod) state_nx = S_EMIT;
         S_EMIT: state_nx = last_pix ? S_DONE : S_MAC;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      do_load = 1'b0;
      do_mac  = 1'b0;
      do_emit = 1'b0;
      do_fin  = 1'b0;
      case (state)
         S_IDLE: do_load = start && !done;
         S_MAC:  do_mac  = 1'b1;
         S_EMIT: do_emit = 1'b1;
         S_DONE: do_fin  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_load) begin
         fm_q <= input_fm;
         w_q  <= weights;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_row   <= '0;
         out_col   <= '0;
         done      <= 1'b0;
         o_cnt     <= '0;
         row_cnt   <= '0;
         col_cnt   <= '0;
         c_cnt     <= '0;
         i_cnt     <= '0;
         j_cnt     <= '0;
         acc       <= '0;
      end else begin
         out_valid <= do_emit;
         done      <= do_fin;
         if (do_load) begin
            busy    <= 1'b1;
            o_cnt   <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            c_cnt   <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            acc     <= '0;
         end
         if (do_fin) busy <= 1'b0;
         if (do_mac) begin
            acc <= acc + prod_ext;
            if (j_cnt == KW'(K-1)) begin
               j_cnt <= '0;
               if (i_cnt == KW'(K-1)) begin
                  i_cnt <= '0;
                  c_cnt <= (c_cnt == ICW'(IN_CH-1)) ? '0 : c_cnt + 1'b1;
               end else begin
                  i_cnt <= i_cnt + 1'b1;
               end
            end else begin
               j_cnt <= j_cnt + 1'b1;
            end
         end
         if (do_emit) begin
            out_data <= emit_val;
            out_ch   <= o_cnt;
            out_row  <= row_cnt;
            out_col  <= col_cnt;
            acc      <= '0;
            if (col_cnt == ODW'(OUT_DIM-1)) begin
               col_cnt <= '0;
               if (row_cnt == ODW'(OUT_DIM-1)) begin
                  row_cnt <= '0;
                  o_cnt   <= (o_cnt == OCW'(OUT_CH-1)) ? '0 : o_cnt + 1'b1;
               end else begin
                  row_cnt <= row_cnt + 1'b1;
               end
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_loop_engine.sv
// tb/tb_conv_loop_engine.sv - bench for conv_loop_engine: default layer plus a strided small instance
module tb_conv_loop_engine;

   localparam int DW = 8, IN_CH = 3, IN_DIM = 12, K = 3, OUT_CH = 7, STRIDE = 1, ACCW = 24;
   localparam int OD  = (IN_DIM - K) / STRIDE + 1;
   localparam int P   = OUT_CH * OD * OD;
   localparam int T   = IN_CH * K * K + 1;
   localparam int FMW = IN_CH * IN_DIM * IN_DIM * DW;
   localparam int WW  = OUT_CH * IN_CH * K * K * DW;

   localparam int S_DIM = 11, S_OD = 5, S_T = 10;

   logic clk = 1'b0;
   logic rst, start;
   logic [FMW-1:0] input_fm;
   logic [WW-1:0]  weights;
   logic busy, out_valid, done;
   logic [ACCW-1:0] out_data;
   logic [2:0] out_ch;
   logic [3:0] out_row, out_col;

   logic s_start;
   logic [S_DIM*S_DIM*DW-1:0] s_fm;
   logic [9*DW-1:0] s_w;
   logic s_busy, s_valid, s_done;
   logic [ACCW-1:0] s_data;
   logic [0:0] s_ch;
   logic [2:0] s_row, s_col;

   int n_cmp = 0, n_bad = 0;

   int fm_a [IN_CH][IN_DIM][IN_DIM];
   int w_a  [OUT_CH][IN_CH][K][K];
   longint exp_a [P];

   always #5 clk = ~clk;

   conv_loop_engine #(.DW(DW), .IN_CH(IN_CH), .IN_DIM(IN_DIM), .K(K), .OUT_CH(OUT_CH),
                      .STRIDE(STRIDE), .ACCW(ACCW)) dut (
      .clk(clk), .rst(rst), .start(start), .input_fm(input_fm), .weights(weights),
      .busy(busy), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_row(out_row), .out_col(out_col), .done(done));

   conv_loop_engine #(.DW(DW), .IN_CH(1), .IN_DIM(S_DIM), .K(3), .OUT_CH(1),
                      .STRIDE(2), .ACCW(ACCW)) s_dut (
      .clk(clk), .rst(rst), .start(s_start), .input_fm(s_fm), .weights(s_w),
      .busy(s_busy), .out_valid(s_valid), .out_data(s_data), .out_ch(s_ch),
      .out_row(s_row), .out_col(s_col), .done(s_done));

   task automatic check(input string tag, input longint got, input longint want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic longint sx(input int v);
      logic signed [DW-1:0] b;
      b = v[DW-1:0];
      return longint'(b);
   endfunction

   function automatic longint wrap(input longint s);
      logic signed [ACCW-1:0] t;
      t = s[ACCW-1:0];
      return longint'(t);
   endfunction

   task automatic pack();
      for (int c = 0; c < IN_CH; c++)
         for (int r = 0; r < IN_DIM; r++)
            for (int x = 0; x < IN_DIM; x++)
               input_fm[((c*IN_DIM+r)*IN_DIM+x)*DW +: DW] = fm_a[c][r][x][DW-1:0];
      for (int o = 0; o < OUT_CH; o++)
         for (int c = 0; c < IN_CH; c++)
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  weights[(((o*IN_CH+c)*K+i)*K+j)*DW +: DW] = w_a[o][c][i][j][DW-1:0];
   endtask

   // convolution computed straight from the array view of the layer
   task automatic model();
      for (int o = 0; o < OUT_CH; o++)
         for (int r = 0; r < OD; r++)
            for (int x = 0; x < OD; x++) begin
               longint s = 0;
               for (int c = 0; c < IN_CH; c++)
                  for (int i = 0; i < K; i++)
                     for (int j = 0; j < K; j++)
                        s += sx(w_a[o][c][i][j]) * sx(fm_a[c][r*STRIDE+i][x*STRIDE+j]);
               s = wrap(s);
`ifdef CONV_RELU_EN
               if (s < 0) s = 0;
`endif
               exp_a[(o*OD+r)*OD+x] = s;
            end
   endtask

   task automatic fill(input int mode);
      for (int c = 0; c < IN_CH; c++)
         for (int r = 0; r < IN_DIM; r++)
            for (int x = 0; x < IN_DIM; x++)
               case (mode)
                  0: fm_a[c][r][x] = 1;
                  1: fm_a[c][r][x] = (c == 0) ? r*12 + x : int'($urandom_range(255)) - 128;
                  2: fm_a[c][r][x] = int'($urandom_range(255)) - 128;
                  default: fm_a[c][r][x] = 2;
               endcase
      for (int o = 0; o < OUT_CH; o++)
         for (int c = 0; c < IN_CH; c++)
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  case (mode)
                     0: w_a[o][c][i][j] = 1;
                     1: w_a[o][c][i][j] = (o == 0 && c == 0 && i == 0 && j == 0) ? 1 : 0;
                     2: w_a[o][c][i][j] = int'($urandom_range(255)) - 128;
                     default: w_a[o][c][i][j] = -1;
                  endcase
   endtask

   task automatic run_layer(input bit disturb);
      int npix;
      bit seen_done;
      npix = 0;
      seen_done = 0;
      pack();
      model();
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k <= P*T + 3 && !seen_done; k++) begin
         @(negedge clk);
         if (k == 0) check("busy_after_start", busy, 1);
         if (out_valid) begin
            if (npix < P) begin
               check("strobe_cycle", k, T*(npix+1));
               check("out_data", longint'($signed(out_data)), exp_a[npix]);
               check("out_ch", out_ch, npix / (OD*OD));
               check("out_row", out_row, (npix / OD) % OD);
               check("out_col", out_col, npix % OD);
            end
            npix++;
         end
         if (done) begin
            seen_done = 1;
            check("done_cycle", k, P*T + 1);
            check("busy_at_done", busy, 0);
            start = 1'b1;
         end else if (disturb) begin
            start = 1'($urandom_range(1));
            if (k % 97 == 5) begin
               input_fm = ~input_fm;
               weights  = ~weights;
            end
         end else begin
            start = 1'b0;
         end
      end
      check("done_seen", seen_done, 1);
      check("pixel_count", npix, P);
      @(negedge clk);
      check("start_with_done_ignored", busy, 0);
      start = 1'b0;
      @(negedge clk);
      check("idle_after_done", busy, 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_coord"}, {out_ch, out_row, out_col}, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      int npix;
      int dones;
      bit seen_done;
      rst = 1'b1;
      start = 1'b0;
      s_start = 1'b0;
      input_fm = '0;
      weights = '0;
      s_fm = '0;
      s_w = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_zero_outputs("reset");
      check("s_reset_valid", s_valid, 0);

      // strided small instance: in(r,x)=x, weights 1
      for (int r = 0; r < S_DIM; r++)
         for (int x = 0; x < S_DIM; x++)
            s_fm[(r*S_DIM+x)*DW +: DW] = DW'(x);
      for (int n = 0; n < 9; n++) s_w[n*DW +: DW] = 8'd1;
      s_start = 1'b1;
      npix = 0;
      seen_done = 0;
      for (int k = 0; k <= S_OD*S_OD*S_T + 3 && !seen_done; k++) begin
         @(negedge clk);
         s_start = 1'b0;
         if (s_valid) begin
            check("s_strobe_cycle", k, S_T*(npix+1));
            check("s_data", s_data, 18*(npix % S_OD) + 9);
            check("s_row", s_row, npix / S_OD);
            check("s_col", s_col, npix % S_OD);
            npix++;
         end
         if (s_done) begin
            seen_done = 1;
            check("s_done_cycle", k, S_OD*S_OD*S_T + 1);
         end
      end
      check("s_done_seen", seen_done, 1);
      check("s_pixel_count", npix, S_OD*S_OD);

      fill(0);
      run_layer(0);
      fill(1);
      run_layer(0);
      fill(2);
      run_layer(1);

      // abort mid-layer, then a full layer with weights -1 and inputs 2
      pack();
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 499) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      check_zero_outputs("abort");
      dones = 0;
      repeat (60) begin
         @(negedge clk);
         if (done || out_valid) dones++;
      end
      check("abort_no_activity", dones, 0);
      fill(3);
      run_layer(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
